// File: rtl/iomem_hakem.sv
`default_nettype none
// ============================================================================
// Module   : iomem_hakem
// Purpose  : Round-robin arbiter between the I-cache and D-cache refill ports
//            onto the registered iomem bus, with a programmable stall timeout.
// Revision : 1.0 - initial release
// ============================================================================
module iomem_hakem #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [1:0] ST_BOS   = 2'd0;
  localparam logic [1:0] ST_ISTEK = 2'd1;
  localparam logic [1:0] ST_YANIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             sahip_q, sahip_d;
  logic             son_sahip_q, son_sahip_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             bus_valid_q, bus_valid_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [3:0]       bus_wstrb_q, bus_wstrb_d;

  logic             m0_ready_q, m0_ready_d;
  logic [31:0]      m0_rdata_q, m0_rdata_d;
  logic             m0_err_q, m0_err_d;
  logic             m1_ready_q, m1_ready_d;
  logic [31:0]      m1_rdata_q, m1_rdata_d;
  logic             m1_err_q, m1_err_d;

  logic             pick_m1;
  logic             finish;
  logic [31:0]      resp_rdata;
  logic             resp_err;
  logic [CNT_W-1:0] cnt_inc;

  // On a tie the master that did not own the previous transaction wins.
  assign pick_m1 = m1_valid & (~m0_valid | ~son_sahip_q);

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // A ready in the timeout cycle still counts as a normal completion.
  always_comb begin
    finish     = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    if (state_q == ST_ISTEK) begin
      if (iomem_ready) begin
        finish     = 1'b1;
        resp_rdata = iomem_rdata;
      end else if (cnt_q == CNT_LAST) begin
        finish   = 1'b1;
        resp_err = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sahip_d     = sahip_q;
    son_sahip_d = son_sahip_q;
    cnt_d       = cnt_q;
    bus_valid_d = bus_valid_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    m0_ready_d  = m0_ready_q;
    m0_rdata_d  = m0_rdata_q;
    m0_err_d    = m0_err_q;
    m1_ready_d  = m1_ready_q;
    m1_rdata_d  = m1_rdata_q;
    m1_err_d    = m1_err_q;

    case (state_q)
      ST_BOS: begin
        if (m0_valid | m1_valid) begin
          bus_valid_d = 1'b1;
          bus_addr_d  = pick_m1 ? m1_addr  : m0_addr;
          bus_wdata_d = pick_m1 ? m1_wdata : m0_wdata;
          bus_wstrb_d = pick_m1 ? m1_wstrb : m0_wstrb;
          sahip_d     = pick_m1;
          cnt_d       = '0;
          state_d     = ST_ISTEK;
        end
      end

      ST_ISTEK: begin
        if (!iomem_ready) begin
          cnt_d = cnt_inc;
        end
        if (finish) begin
          bus_valid_d = 1'b0;
          son_sahip_d = sahip_q;
          state_d     = ST_YANIT;
          if (sahip_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = resp_rdata;
            m1_err_d   = resp_err;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = resp_rdata;
            m0_err_d   = resp_err;
          end
        end
      end

      ST_YANIT: begin
        m0_ready_d = 1'b0;
        m0_rdata_d = 32'h0;
        m0_err_d   = 1'b0;
        m1_ready_d = 1'b0;
        m1_rdata_d = 32'h0;
        m1_err_d   = 1'b0;
        state_d    = ST_BOS;
      end

      default: begin
        state_d = ST_BOS;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_BOS;
      sahip_q     <= 1'b0;
      son_sahip_q <= 1'b1;
      cnt_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_wstrb_q <= 4'h0;
      m0_ready_q  <= 1'b0;
      m0_rdata_q  <= 32'h0;
      m0_err_q    <= 1'b0;
      m1_ready_q  <= 1'b0;
      m1_rdata_q  <= 32'h0;
      m1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sahip_q     <= sahip_d;
      son_sahip_q <= son_sahip_d;
      cnt_q       <= cnt_d;
      bus_valid_q <= bus_valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      m0_ready_q  <= m0_ready_d;
      m0_rdata_q  <= m0_rdata_d;
      m0_err_q    <= m0_err_d;
      m1_ready_q  <= m1_ready_d;
      m1_rdata_q  <= m1_rdata_d;
      m1_err_q    <= m1_err_d;
    end
  end

  assign iomem_valid = bus_valid_q;
  assign iomem_addr  = bus_addr_q;
  assign iomem_wdata = bus_wdata_q;
  assign iomem_wstrb = bus_wstrb_q;

  assign m0_ready = m0_ready_q;
  assign m0_rdata = m0_rdata_q;
  assign m0_err   = m0_err_q;
  assign m1_ready = m1_ready_q;
  assign m1_rdata = m1_rdata_q;
  assign m1_err   = m1_err_q;

endmodule
`default_nettype wire

// File: tb/tb_iomem_hakem.sv
`default_nettype none
// ============================================================================
// Module   : tb_iomem_hakem
// Purpose  : Directed and randomized self-checking bench for iomem_hakem.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iomem_hakem;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr, iomem_wdata;
  logic [31:0] iomem_rdata = '0;

  int checks = 0;
  int errors = 0;

  // Reference model: pending request per master and the last bus owner.
  bit          p_valid [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];
  logic [3:0]  p_wstrb [2];
  int          last_owner;

  iomem_hakem #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_of(input int m);
    return (m == 1) ? m1_ready : m0_ready;
  endfunction
  function automatic logic [31:0] rdata_of(input int m);
    return (m == 1) ? m1_rdata : m0_rdata;
  endfunction
  function automatic logic err_of(input int m);
    return (m == 1) ? m1_err : m0_err;
  endfunction

  task automatic present(input int m, input logic [31:0] a, input logic [31:0] w,
                         input logic [3:0] s);
    p_valid[m] = 1'b1; p_addr[m] = a; p_wdata[m] = w; p_wstrb[m] = s;
    if (m == 0) begin
      m0_valid = 1'b1; m0_addr = a; m0_wdata = w; m0_wstrb = s;
    end else begin
      m1_valid = 1'b1; m1_addr = a; m1_wdata = w; m1_wstrb = s;
    end
  endtask

  task automatic drop(input int m);
    p_valid[m] = 1'b0;
    if (m == 0) m0_valid = 1'b0;
    else        m1_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, {31'h0, iomem_valid}, 32'h0);
    chk({tag, "_rdy"}, {30'h0, m1_ready, m0_ready}, 32'h0);
    chk({tag, "_rdata"}, m0_rdata | m1_rdata, 32'h0);
    chk({tag, "_err"}, {30'h0, m1_err, m0_err}, 32'h0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    chk("reset_bus", iomem_addr | iomem_wdata | {28'h0, iomem_wstrb}, 32'h0);
    resetn = 1'b1;
    last_owner = 1;
  endtask

  // One transaction from the grant edge to the response cycle. The memory
  // answers after `waits` wait states; waits >= TO means it never does.
  task automatic bus_txn(input int own, input int waits, input logic [31:0] rd);
    logic [31:0] ea, ew;
    logic [3:0]  es;
    bit          to;
    bit          done;
    int          n;
    ea = p_addr[own]; ew = p_wdata[own]; es = p_wstrb[own];
    to = (waits >= TO);
    tick();
    n = 0;
    done = 1'b0;
    while (!done) begin
      chk("istek_valid", {31'h0, iomem_valid}, 32'h1);
      chk("istek_addr", iomem_addr, ea);
      chk("istek_wdata", iomem_wdata, ew);
      chk("istek_wstrb", {28'h0, iomem_wstrb}, {28'h0, es});
      chk("istek_rdy", {30'h0, m1_ready, m0_ready}, 32'h0);
      iomem_ready = (n == waits);
      iomem_rdata = (n == waits) ? rd : $urandom();
      tick();
      if (n == waits || n == TO - 1) done = 1'b1;
      n++;
    end
    iomem_ready = 1'b0;
    chk("resp_bus_drop", {31'h0, iomem_valid}, 32'h0);
    chk("resp_own_rdy", {31'h0, rdy_of(own)}, 32'h1);
    chk("resp_own_rdata", rdata_of(own), to ? 32'h0 : rd);
    chk("resp_own_err", {31'h0, err_of(own)}, {31'h0, to});
    chk("resp_oth_rdy", {31'h0, rdy_of(1 - own)}, 32'h0);
    chk("resp_oth_rdata", rdata_of(1 - own), 32'h0);
    chk("resp_oth_err", {31'h0, err_of(1 - own)}, 32'h0);
    last_owner = own;
    drop(own);
  endtask

  task automatic yanit(input bit late);
    iomem_ready = late;
    iomem_rdata = $urandom();
    tick();
    iomem_ready = 1'b0;
    check_quiet("yanit");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int win;
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    last_owner = 1;

    // Zero-wait read on master 0
    do_reset();
    present(0, 32'h4000_0000, 32'h0, 4'h0);
    bus_txn(0, 0, 32'h1234_5678);
    yanit(1'b0);

    // Both masters from reset: strict alternation
    do_reset();
    present(0, 32'h0000_1000, 32'h0, 4'h0);
    present(1, 32'h2000_0010, 32'hCAFE_BABE, 4'hF);
    bus_txn(0, 0, 32'h1111_0000);
    present(0, 32'h0000_1004, 32'h0, 4'h0);
    yanit(1'b0);
    bus_txn(1, 1, 32'h2222_0000);
    present(1, 32'h2000_0014, 32'h0BAD_F00D, 4'h3);
    yanit(1'b0);
    bus_txn(0, 2, 32'h3333_0000);
    yanit(1'b0);
    bus_txn(1, 0, 32'h4444_0000);
    yanit(1'b0);

    // Five wait states
    present(0, 32'h4000_0100, 32'h0000_0055, 4'h1);
    bus_txn(0, 5, 32'hDEAD_0005);
    yanit(1'b0);

    // Timeout with a late ready in YANIT and BOS
    present(1, 32'h8000_0000, 32'h0, 4'h0);
    bus_txn(1, 1000, 32'hFFFF_FFFF);
    yanit(1'b1);
    iomem_ready = 1'b1;
    tick();
    iomem_ready = 1'b0;
    check_quiet("late_bos");

    // Ready coincident with the timeout cycle
    present(0, 32'h4000_0200, 32'h0, 4'h0);
    bus_txn(0, TO - 1, 32'hA5A5_0001);
    yanit(1'b0);

    // Reset during ISTEK of an m0 read
    present(0, 32'h4000_0300, 32'h0, 4'h0);
    tick();
    chk("pre_rst_valid", {31'h0, iomem_valid}, 32'h1);
    present(1, 32'h2000_0300, 32'h1357_9BDF, 4'hC);
    tick();
    tick();
    #3 resetn = 1'b0;
    #1;
    chk("rst_async_valid", {31'h0, iomem_valid}, 32'h0);
    chk("rst_async_rdy", {31'h0, m0_ready}, 32'h0);
    tick();
    tick();
    chk("rst_hold_rdy", {30'h0, m1_ready, m0_ready}, 32'h0);
    resetn = 1'b1;
    last_owner = 1;
    bus_txn(0, 2, 32'h0F0F_0F0F);
    yanit(1'b0);
    bus_txn(1, 0, 32'hF0F0_F0F0);
    yanit(1'b0);

    // Randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      for (int m = 0; m < 2; m++) begin
        if (!p_valid[m] && $urandom_range(0, 2) != 0)
          present(m, $urandom(), $urandom(), 4'($urandom()));
      end
      if (!p_valid[0] && !p_valid[1]) begin
        tick();
        check_quiet("idle");
        continue;
      end
      if (p_valid[0] && p_valid[1]) win = 1 - last_owner;
      else                          win = p_valid[1] ? 1 : 0;
      bus_txn(win, $urandom_range(0, 10), $urandom());
      if ($urandom_range(0, 1) == 1)
        present(win, $urandom(), $urandom(), 4'($urandom()));
      yanit(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
